// File: rtl/usb_audio_in_packer_if.sv
// Byte-stream link from the audio packer to the USB core IN endpoint.
//   in_data  : byte offered to the endpoint
//   in_valid : in_data holds a valid byte
//   in_ready : the endpoint takes the byte in this cycle
// master = packer (byte source), slave = USB core (byte sink).
interface usb_audio_in_packer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/usb_audio_in_packer.sv
// USB audio IN packer: samples a stereo 16-bit ADC pair once per 48 kHz
// period, converts it to two's complement and collects FRAMES frames into
// one half of a ping-pong buffer. A completed half is streamed byte by byte
// to the USB IN endpoint (L lo, L hi, R lo, R hi per frame). If the sender
// still owns the other half when a fill completes, the fill half is
// overwritten and overflow_cnt counts the lost buffer.
// Ports:
//   clk          : 60 MHz clock, rising edge
//   rstn         : asynchronous active-low reset
//   audio_lch/rch: offset-binary ADC samples
//   in_if        : byte stream to the USB core (master side)
//   overflow_cnt : saturating count of discarded buffers
//   busy         : high while a packet is being sent
module usb_audio_in_packer #(
    parameter int CLK_DIV = 1250,
    parameter int FRAMES  = 48
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [15:0]                  audio_lch,
    input  logic [15:0]                  audio_rch,
    usb_audio_in_packer_if.master        in_if,
    output logic [7:0]                   overflow_cnt,
    output logic                         busy
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int BYTES  = FRAMES * 4;
    localparam int BYTE_W = IDX_W + 2;
    localparam int MEM_W  = $clog2(2 * FRAMES);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_STROBE = CNT_W'(CLK_DIV / 2);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(FRAMES - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(BYTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Offset-binary to two's complement: flip the MSB.
    function automatic logic [15:0] to_signed16(input logic [15:0] s);
        return {~s[15], s[14:0]};
    endfunction

    // Byte lane of a stored frame {L, R}: L lo, L hi, R lo, R hi.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[23:16];
            2'd1:    b = w[31:24];
            2'd2:    b = w[7:0];
            default: b = w[15:8];
        endcase
        return b;
    endfunction

    // Flat address of frame idx inside buffer half sel.
    function automatic logic [MEM_W-1:0] mem_addr(input logic sel, input logic [IDX_W-1:0] idx);
        return sel ? (MEM_W'(FRAMES) + MEM_W'(idx)) : MEM_W'(idx);
    endfunction

    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  wr_idx_r;
    logic              fill_sel_r;
    logic [1:0]        full_r;
    logic [1:0]        full_next_s;
    logic [7:0]        ovf_r;
    logic [31:0]       mem_r [0:2*FRAMES-1];

    state_t            state_r;
    state_t            state_next_s;
    logic              send_sel_r;
    logic [BYTE_W-1:0] rd_byte_r;
    logic [7:0]        in_data_r;
    logic              in_valid_r;
    logic              busy_r;

    logic              strobe_s;
    logic              fill_last_s;
    logic              other_busy_s;
    logic              swap_s;
    logic              ovf_s;
    logic              load_s;
    logic              advance_s;
    logic              release_s;
    logic              rd_sel_s;
    logic [BYTE_W-1:0] rd_next_s;
    logic [31:0]       rd_word_s;

    assign strobe_s    = (cnt_r == CNT_STROBE);
    assign fill_last_s = strobe_s && (wr_idx_r == IDX_LAST);
    // A release in this very cycle frees the other half for the swap.
    assign other_busy_s = full_r[~fill_sel_r] && !release_s;
    assign swap_s       = fill_last_s && !other_busy_s;
    assign ovf_s        = fill_last_s && other_busy_s;

    // Sample-period counter; the strobe sits mid-period.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Full flags: sender release clears, fill completion sets.
    always_comb begin
        full_next_s = full_r;
        if (release_s) begin
            full_next_s[send_sel_r] = 1'b0;
        end else begin
            full_next_s = full_next_s;
        end
        if (swap_s) begin
            full_next_s[fill_sel_r] = 1'b1;
        end else begin
            full_next_s = full_next_s;
        end
    end

    // Fill bookkeeping: frame index, ping-pong select, full flags, overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_idx_r   <= {IDX_W{1'b0}};
            fill_sel_r <= 1'b0;
            full_r     <= 2'b00;
            ovf_r      <= 8'd0;
        end else begin
            full_r <= full_next_s;
            if (fill_last_s) begin
                wr_idx_r <= {IDX_W{1'b0}};
            end else if (strobe_s) begin
                wr_idx_r <= wr_idx_r + IDX_W'(1);
            end
            if (swap_s) begin
                fill_sel_r <= ~fill_sel_r;
            end
            if (ovf_s && (ovf_r != 8'hFF)) begin
                ovf_r <= ovf_r + 8'd1;
            end
        end
    end

    // Sample capture into the fill half; contents need no reset.
    always_ff @(posedge clk) begin
        if (strobe_s) begin
            mem_r[mem_addr(fill_sel_r, wr_idx_r)] <= {to_signed16(audio_lch), to_signed16(audio_rch)};
        end
    end

    // Sender next-state logic.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|full_r) begin
                    state_next_s = ST_SEND;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (in_if.in_ready) begin
                    if (rd_byte_r == BYTE_LAST) begin
                        state_next_s = ST_IDLE;
                        release_s    = 1'b1;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sender state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Read address of the byte presented next: byte 0 of the non-fill half
    // on packet start, otherwise the following byte of the send half.
    always_comb begin
        rd_sel_s  = send_sel_r;
        rd_next_s = rd_byte_r + BYTE_W'(1);
        if (load_s) begin
            rd_sel_s  = ~fill_sel_r;
            rd_next_s = {BYTE_W{1'b0}};
        end else begin
            rd_sel_s  = send_sel_r;
            rd_next_s = rd_byte_r + BYTE_W'(1);
        end
        rd_word_s = mem_r[mem_addr(rd_sel_s, rd_next_s[BYTE_W-1:2])];
    end

    // Registered byte stream: data only moves on start or acceptance,
    // so it holds while the core stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            send_sel_r <= 1'b0;
            rd_byte_r  <= {BYTE_W{1'b0}};
            in_data_r  <= 8'd0;
            in_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            in_valid_r <= (state_next_s == ST_SEND);
            busy_r     <= (state_next_s == ST_SEND);
            if (load_s) begin
                send_sel_r <= ~fill_sel_r;
                rd_byte_r  <= {BYTE_W{1'b0}};
                in_data_r  <= pick_byte(rd_word_s, 2'd0);
            end else if (advance_s) begin
                rd_byte_r  <= rd_next_s;
                in_data_r  <= pick_byte(rd_word_s, rd_next_s[1:0]);
            end
        end
    end

    assign in_if.in_data  = in_data_r;
    assign in_if.in_valid = in_valid_r;
    assign overflow_cnt   = ovf_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_usb_audio_in_packer.sv
// Directed bench for usb_audio_in_packer with a short sample period
// (CLK_DIV=20, strobe on the edge after cnt==10) and FRAMES=4 (16-byte
// packets). Edge numbers count rising edges since reset release; strobes
// land on edges 11, 31, 51, ... so a buffer completes on edges 71, 151, ...
module tb_usb_audio_in_packer;
    localparam int CLK_DIV = 20;
    localparam int FRAMES  = 4;
    localparam int PKT     = FRAMES * 4;
    localparam int STROBE1 = CLK_DIV / 2 + 1;

    logic        clk;
    logic        rstn;
    logic [15:0] audio_lch;
    logic [15:0] audio_rch;
    logic [7:0]  overflow_cnt;
    logic        busy;

    usb_audio_in_packer_if bus ();

    usb_audio_in_packer #(.CLK_DIV(CLK_DIV), .FRAMES(FRAMES)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .audio_lch    (audio_lch),
        .audio_rch    (audio_rch),
        .in_if        (bus),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          audio_ramp = 1'b0;
    logic [15:0] ramp_base = 16'h0000;
    logic [15:0] const_l = 16'h0000;
    logic [15:0] const_r = 16'h0000;
    logic [7:0]  rx_q [$];
    int          pkt_len_q [$];
    int          cur_len = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected byte i of a ramp stream: frame n carries lch=base+n, rch=~(base+n).
    function automatic logic [7:0] exp_byte(input logic [15:0] base, input int i);
        logic [15:0] v;
        logic [15:0] l;
        logic [15:0] r;
        logic [7:0]  b;
        v = base + 16'(i / 4);
        l = v ^ 16'h8000;
        r = (~v) ^ 16'h8000;
        case (i % 4)
            0:       b = l[7:0];
            1:       b = l[15:8];
            2:       b = r[7:0];
            default: b = r[15:8];
        endcase
        return b;
    endfunction

    // Audio driver and edge counter: changes inputs 1 ns after each edge so
    // frame n is stable on strobe edge STROBE1 + n*CLK_DIV.
    initial begin
        int nf;
        audio_lch = 16'h0000;
        audio_rch = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) cyc = 0;
            else       cyc = cyc + 1;
            nf = (cyc < STROBE1) ? 0 : (cyc - STROBE1) / CLK_DIV + 1;
            if (audio_ramp) begin
                audio_lch = ramp_base + 16'(nf);
                audio_rch = ~(ramp_base + 16'(nf));
            end else begin
                audio_lch = const_l;
                audio_rch = const_r;
            end
        end
    end

    // Stream monitor on the falling edge: collects accepted bytes, packet
    // lengths, and checks hold-while-stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cur_len    = 0;
                prev_stall = 1'b0;
                rx_q.delete();
                pkt_len_q.delete();
            end else begin
                if (prev_stall) begin
                    check_eq("stall_valid", bus.in_valid, 1'b1);
                    check_eq("stall_data", bus.in_data, prev_data);
                end
                if (bus.in_valid && bus.in_ready) begin
                    rx_q.push_back(bus.in_data);
                    cur_len++;
                end
                if (!bus.in_valid && cur_len != 0) begin
                    pkt_len_q.push_back(cur_len);
                    cur_len = 0;
                end
                prev_stall = bus.in_valid && !bus.in_ready;
                prev_data  = bus.in_data;
            end
        end
    end

    task automatic assert_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (cyc < e && guard < 20000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check_eq("edge_reached", (cyc >= e) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_pkts(input int n, input int budget);
        int guard = 0;
        while (pkt_len_q.size() < n && guard < budget) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check_eq("pkt_count", (pkt_len_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [15:0] base, input int npkt);
        int need = npkt * PKT;
        check_eq({tag, "_enough"}, (rx_q.size() >= need) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < need && i < rx_q.size(); i++)
            check_eq($sformatf("%s_b%0d", tag, i), rx_q[i], exp_byte(base, i));
        for (int p = 0; p < npkt && p < pkt_len_q.size(); p++)
            check_eq($sformatf("%s_len%0d", tag, p), pkt_len_q[p], PKT);
    endtask

    initial begin
        logic [7:0] pat [4];
        int guard;
        pat = '{8'h01, 8'h00, 8'hFF, 8'hFF};
        bus.in_ready = 1'b0;
        rstn = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        check_eq("rst_valid", bus.in_valid, 1'b0);
        check_eq("rst_data", bus.in_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ovf", overflow_cnt, 8'h00);

        // Constant 8001/7FFF -> 01 00 FF FF repeated, two packets.
        audio_ramp = 1'b0;
        const_l = 16'h8001;
        const_r = 16'h7FFF;
        bus.in_ready = 1'b1;
        release_reset();
        wait_pkts(2, 400);
        check_eq("const_enough", (rx_q.size() >= 2 * PKT) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 2 * PKT && i < rx_q.size(); i++)
            check_eq($sformatf("const_b%0d", i), rx_q[i], pat[i % 4]);
        for (int p = 0; p < 2 && p < pkt_len_q.size(); p++)
            check_eq($sformatf("const_len%0d", p), pkt_len_q[p], PKT);

        // Ramp over ten packets, plus first-packet timing.
        assert_reset();
        audio_ramp = 1'b1;
        ramp_base = 16'h0000;
        bus.in_ready = 1'b1;
        release_reset();
        wait_edge(70);
        @(negedge clk);
        check_eq("first_valid_early", bus.in_valid, 1'b0);
        wait_edge(74);
        @(negedge clk);
        check_eq("first_valid_late", bus.in_valid, 1'b1);
        check_eq("first_busy", busy, 1'b1);
        wait_pkts(10, 1200);
        check_stream("ramp", 16'h0000, 10);
        check_eq("ramp_ovf", overflow_cnt, 8'h00);

        // Random ready at 50%.
        assert_reset();
        ramp_base = 16'h1234;
        release_reset();
        guard = 0;
        while (pkt_len_q.size() < 3 && guard < 800) begin
            @(posedge clk);
            #2;
            bus.in_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        bus.in_ready = 1'b1;
        check_stream("rand", 16'h1234, 3);
        check_eq("rand_ovf", overflow_cnt, 8'h00);

        // Ready stuck low: overflow counts 1, 2, 3; stalled byte unchanged.
        assert_reset();
        ramp_base = 16'h0020;
        bus.in_ready = 1'b0;
        release_reset();
        wait_edge(150);
        @(negedge clk);
        check_eq("stuck_ovf0", overflow_cnt, 8'd0);
        wait_edge(151);
        @(negedge clk);
        check_eq("stuck_ovf1", overflow_cnt, 8'd1);
        check_eq("stuck_valid", bus.in_valid, 1'b1);
        check_eq("stuck_data1", bus.in_data, 8'h20);
        wait_edge(231);
        @(negedge clk);
        check_eq("stuck_ovf2", overflow_cnt, 8'd2);
        wait_edge(311);
        @(negedge clk);
        check_eq("stuck_ovf3", overflow_cnt, 8'd3);
        check_eq("stuck_data3", bus.in_data, 8'h20);
        check_eq("stuck_busy", busy, 1'b1);
        check_eq("stuck_nobytes", rx_q.size(), 0);

        // Reset mid-packet, then a fresh packet from byte 0.
        assert_reset();
        ramp_base = 16'h0010;
        bus.in_ready = 1'b1;
        release_reset();
        guard = 0;
        while (rx_q.size() < 10 && guard < 300) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check_eq("mid_reached", rx_q.size(), 10);
        check_eq("mid_valid_pre", bus.in_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_valid", bus.in_valid, 1'b0);
        check_eq("mid_rst_data", bus.in_data, 8'h00);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_ovf", overflow_cnt, 8'h00);
        ramp_base = 16'h0040;
        release_reset();
        wait_edge(70);
        @(negedge clk);
        check_eq("mid_no_resume", bus.in_valid, 1'b0);
        wait_pkts(1, 300);
        check_stream("after_rst", 16'h0040, 1);

        // Last-byte release on the same edge as the buffer-completing strobe.
        assert_reset();
        ramp_base = 16'h0030;
        bus.in_ready = 1'b1;
        release_reset();
        guard = 0;
        while (pkt_len_q.size() < 2 && guard < 500) begin
            @(posedge clk);
            #2;
            if (cyc == 150) check_eq("coinc_stalled15", rx_q.size(), PKT - 1);
            bus.in_ready = (cyc >= 150) || (rx_q.size() < PKT - 1);
            guard++;
        end
        bus.in_ready = 1'b1;
        check_stream("coinc", 16'h0030, 2);
        check_eq("coinc_ovf", overflow_cnt, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_audio_in_packer.md
USB_AUDIO_IN_PACKER -- requirements
Module: usb_audio_in_packer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1250, meaning clk cycles per 48 kHz sample period (60 MHz / 48 kHz).
REQ-002 SHALL have parameter FRAMES, default 48, meaning stereo frames per packet buffer (1 ms at 48 kHz); packet length = FRAMES*4 bytes (192).
REQ-003 SHALL have port `clk`, input, 1 bit: single clock, 60 MHz; all logic on its rising edge.
REQ-004 SHALL have port `rstn`, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port `audio_lch`, input, 16 bits: ADC left sample, unsigned offset-binary.
REQ-006 SHALL have port `audio_rch`, input, 16 bits: ADC right sample, unsigned offset-binary.
REQ-007 SHALL have port `in_data`, output, 8 bits: byte to the USB core IN endpoint.
REQ-008 SHALL have port `in_valid`, output, 1 bit: `in_data` holds a valid byte.
REQ-009 SHALL have port `in_ready`, input, 1 bit: the USB core accepts the byte this cycle.
REQ-010 SHALL have port `overflow_cnt`, output, 8 bits: count of discarded buffers, saturating.
REQ-011 SHALL have port `busy`, output, 1 bit: high while the sender state is SEND.

Function
REQ-012 Sample tick: cnt SHALL run 0..CLK_DIV-1 and then wrap; the sample strobe SHALL fire when cnt==CLK_DIV/2 (625), once per period.
REQ-013 On each strobe, SHALL capture {audio_lch, audio_rch} into the fill buffer at frame index wr_idx, then increment wr_idx.
REQ-014 Format: each sample SHALL be stored signed, as {~s[15], s[14:0]} (offset-binary to two's complement).
REQ-015 Two buffers (ping-pong), each FRAMES entries of 32 bits. fill_sel selects the buffer being written; full[1:0] flags buffers handed to the sender.
REQ-016 When the strobe writes frame FRAMES-1 and the other buffer is not full, SHALL set full[fill_sel], toggle fill_sel and clear wr_idx to 0, all in the same cycle.
REQ-017 When the strobe writes frame FRAMES-1 and the other buffer is still full, SHALL keep fill_sel, clear wr_idx to 0 (the fill buffer is overwritten) and increment overflow_cnt, saturating at 255.
REQ-018 Sender FSM states: IDLE, SEND.
REQ-019 IDLE -> SEND when any full bit is set; the buffer chosen SHALL be the one not equal to fill_sel; rd_byte SHALL be set to 0.
REQ-020 SEND: `in_valid`=1. Byte order per frame: L[7:0], L[15:8], R[7:0], R[15:8]; frames in ascending index order.
REQ-021 On `in_valid`&&`in_ready`, rd_byte SHALL advance by 1.
REQ-022 On acceptance of byte FRAMES*4-1: SHALL clear the sent buffer's full bit, go to IDLE, and deassert `in_valid` for at least one cycle (packet boundary).
REQ-023 Handshake: while `in_valid`=1 and `in_ready`=0, `in_data` SHALL hold stable; `in_valid` SHALL NOT drop mid-packet.
REQ-024 Latency: `in_valid` SHALL rise no later than 3 cycles after the full bit is set; buffer reads may be registered, but `in_data` SHALL be correct whenever `in_valid`=1.
REQ-025 `in_ready` asserted while `in_valid`=0 SHALL be ignored.
REQ-026 Simultaneous events: a clear of a full bit (REQ-022) and a fill completion (REQ-016/017) in the same cycle SHALL see the buffer as released, so REQ-016 applies.
REQ-027 Writes to the fill buffer SHALL never alter the buffer being sent.

Reset
REQ-028 On `rstn`=0, asynchronously: cnt=0, wr_idx=0, fill_sel=0, full=00, FSM=IDLE, rd_byte=0, `in_valid`=0, `in_data`=0, `overflow_cnt`=0, `busy`=0.
REQ-029 Buffer contents need no reset; reset mid-packet SHALL abort the packet, and no partial continuation SHALL follow release.
REQ-030 After release, the first strobe SHALL occur at cycle 625 of the first period.

Verification
REQ-031 Hold lch=16'h8001, rch=16'h7FFF, `in_ready`=1 -> after 48 strobes, 192 bytes are sent, repeating the pattern 01 00 FF FF; `in_valid` low between packets.
REQ-032 Ramp lch=n, rch=~n per frame n -> byte sequence matches; `overflow_cnt`=0 over 10 packets.
REQ-033 Random `in_ready` at 50% duty -> `in_data` stays stable while stalled, no byte is lost or duplicated, and each packet is exactly 192 bytes.
REQ-034 `in_ready`=0 permanently -> first packet stalls at byte 0; at the end of the 2nd fill period `overflow_cnt`=1, then 2, 3 for subsequent periods; the stalled packet data is unchanged.
REQ-035 Assert `rstn`=0 at byte 100 of a packet -> all outputs are at reset values immediately; after release, the next packet starts at byte 0 with fresh data after 48 strobes.
REQ-036 Force the release of byte 191 and the 48th strobe into the same cycle -> buffer swaps, `overflow_cnt` unchanged, and the next packet is sent.
